// File: rtl/wb_cmd_fifo_if.sv
// Wishbone slave port plus the command stream toward the motion engine.
// Signal names keep the _i/_o sense as seen from the FIFO (slave) side.
interface wb_cmd_fifo_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        cmd_valid_o;
   logic [31:0] cmd_data_o;
   logic        cmd_ready_i;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output cmd_valid_o, cmd_data_o,
      input  cmd_ready_i
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  cmd_valid_o, cmd_data_o,
      output cmd_ready_i
   );
endinterface

// File: rtl/wb_cmd_fifo.sv
// Wishbone-written command FIFO feeding the motion engine over valid/ready.
// Latency: registered ack one cycle after select; pushed word visible on the stream next cycle.
// Backpressure: cmd_ready_i stalls the head; writes to a full FIFO are acked, dropped and flag OVF.
module wb_cmd_fifo #(
   parameter int          DEPTH_LOG2 = 3,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          LOW_WATER  = 2
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_ni,
   wb_cmd_fifo_if.slave bus,
   output logic         lowwater_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LVL_LOW  = (DEPTH_LOG2 + 1)'(LOW_WATER);

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic                  ovf;
   logic                  empty;
   logic                  full;
   logic                  acc;
   logic [1:0]            reg_idx;
   logic                  push_req;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  ovf_clr;
   logic [31:0]           status;

   assign empty      = (level == '0);
   assign full       = (level == LVL_FULL);
   assign lowwater_o = (level <= LVL_LOW);

   // The !ack term limits a held strobe to one access every other cycle.
   assign acc = bus.wbs_cyc_i && bus.wbs_stb_i && !bus.wbs_ack_o &&
                (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign reg_idx = bus.wbs_adr_i[3:2];

   assign push_req = acc && bus.wbs_we_i && (reg_idx == 2'd0) && (bus.wbs_sel_i == 4'hF);
   assign push     = push_req && !full;
   assign flush    = acc && bus.wbs_we_i && (reg_idx == 2'd2) && bus.wbs_dat_i[0];
   assign ovf_clr  = acc && bus.wbs_we_i && (reg_idx == 2'd2) && bus.wbs_dat_i[1];
   assign pop      = !empty && bus.cmd_ready_i;

   assign bus.cmd_valid_o = !empty;
   assign bus.cmd_data_o  = empty ? '0 : mem[rd_ptr];

   always_comb begin
      status                 = '0;
      status[DEPTH_LOG2:0]   = level;
      status[16]             = empty;
      status[17]             = full;
      status[18]             = ovf;
      status[19]             = lowwater_o;
   end

   // Storage needs no reset: the head is gated by empty.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem[wr_ptr] <= bus.wbs_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ovf           <= 1'b0;
         bus.wbs_ack_o <= 1'b0;
         bus.wbs_dat_o <= '0;
      end else begin
         if (push_req && full) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         bus.wbs_ack_o <= acc;
         bus.wbs_dat_o <= (acc && !bus.wbs_we_i && (reg_idx == 2'd1)) ? status : '0;
      end
   end
endmodule

// File: tb/tb_wb_cmd_fifo.sv
// Randomized and directed bench for wb_cmd_fifo against a queue-based reference model.
module tb_wb_cmd_fifo;
   localparam logic [31:0] A_CMD  = 32'h3000_0000;
   localparam logic [31:0] A_STAT = 32'h3000_0004;
   localparam logic [31:0] A_CTRL = 32'h3000_0008;
   localparam logic [31:0] A_RSV  = 32'h3000_000C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic lowwater;
   int   n_cmp = 0;
   int   n_bad = 0;

   wb_cmd_fifo_if bus();

   wb_cmd_fifo #(.DEPTH_LOG2(3), .BASE_ADDR(32'h3000_0000), .LOW_WATER(2)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus),
      .lowwater_o(lowwater)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a queue of pending words, the sticky overflow bit and the expected bus reply.
   logic [31:0] mq[$];
   bit          m_ovf = 1'b0;
   bit          m_ack = 1'b0;
   logic [31:0] m_dat = '0;
   bit          m_sel, m_pop, m_full, m_push, m_flush, m_clr;
   logic [1:0]  m_idx;

   function automatic logic [31:0] m_status();
      int lv = mq.size();
      return {12'h0, (lv <= 2), m_ovf, (lv == 8), (lv == 0), 12'h0, 4'(lv)};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
         m_ack = 1'b0;
         m_dat = '0;
         chk("rst_ack", bus.wbs_ack_o, 0);
         chk("rst_dat", bus.wbs_dat_o, 0);
         chk("rst_valid", bus.cmd_valid_o, 0);
         chk("rst_head", bus.cmd_data_o, 0);
         chk("rst_lowwater", lowwater, 1);
      end else begin
         chk("ack", bus.wbs_ack_o, m_ack);
         chk("dat_o", bus.wbs_dat_o, m_dat);
         chk("valid", bus.cmd_valid_o, mq.size() != 0);
         chk("head", bus.cmd_data_o, (mq.size() != 0) ? mq[0] : 32'h0);
         chk("lowwater", lowwater, mq.size() <= 2);

         m_sel   = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack && (bus.wbs_adr_i[31:4] == 28'h300_0000);
         m_idx   = bus.wbs_adr_i[3:2];
         m_full  = (mq.size() == 8);
         m_pop   = (mq.size() != 0) && bus.cmd_ready_i;
         m_push  = m_sel && bus.wbs_we_i && m_idx == 2'd0 && bus.wbs_sel_i == 4'hF;
         m_flush = m_sel && bus.wbs_we_i && m_idx == 2'd2 && bus.wbs_dat_i[0];
         m_clr   = m_sel && bus.wbs_we_i && m_idx == 2'd2 && bus.wbs_dat_i[1];

         m_dat = (m_sel && !bus.wbs_we_i && m_idx == 2'd1) ? m_status() : 32'h0;
         m_ack = m_sel;

         if (m_flush) mq.delete();
         else if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (m_full) m_ovf = 1'b1;
            else mq.push_back(bus.wbs_dat_i);
         end
         if (m_clr) m_ovf = 1'b0;
      end
   end

   task automatic wb_acc(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input logic rdy, output logic [31:0] rdat);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
      bus.cmd_ready_i = rdy;
      @(posedge clk); #1;
      chk("acc_ack", bus.wbs_ack_o, 1);
      rdat = bus.wbs_dat_o;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.cmd_ready_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] unused_rd;
      wb_acc(adr, 1'b1, 4'hF, dat, 1'b0, unused_rd);
   endtask

   task automatic rd_status(input string tag, input logic [31:0] exp);
      logic [31:0] r;
      wb_acc(A_STAT, 1'b0, 4'hF, 32'h0, 1'b0, r);
      chk(tag, r, exp);
   endtask

   initial begin
      logic [31:0] exp3 [3];
      logic [31:0] r;
      int          k;
      exp3 = '{32'hA1, 32'hB2, 32'hC3};
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
      bus.cmd_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      rd_status("status_reset", 32'h0009_0000);
      chk("valid_after_reset", bus.cmd_valid_o, 0);

      for (int i = 0; i < 3; i++) wr(A_CMD, exp3[i]);
      rd_status("status_lvl3", 32'h0000_0003);
      @(posedge clk); #1 bus.cmd_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stream_valid", bus.cmd_valid_o, 1);
         chk("stream_word", bus.cmd_data_o, exp3[i]);
         @(posedge clk); #1;
      end
      chk("stream_drained", bus.cmd_valid_o, 0);
      bus.cmd_ready_i = 1'b0;

      for (int i = 0; i < 9; i++) wr(A_CMD, $urandom);
      rd_status("status_overflow", 32'h0006_0008);
      wr(A_CTRL, 32'h2);
      rd_status("status_ovf_clr", 32'h0002_0008);

      // Full FIFO: push and pop on the same edge, push must be rejected.
      wb_acc(A_CMD, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, r);
      rd_status("status_full_pushpop", 32'h0004_0007);
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 4; i++) wr(A_CMD, 32'h100 + i);
      wb_acc(A_CMD, 1'b1, 4'hF, 32'h104, 1'b1, r);
      rd_status("status_lvl4_pushpop", 32'h0000_0004);
      @(posedge clk); #1 bus.cmd_ready_i = 1'b1;
      repeat (6) @(posedge clk);
      #1 bus.cmd_ready_i = 1'b0;
      chk("drain_lvl4", bus.cmd_valid_o, 0);

      wr(A_CMD, 32'h11); wr(A_CMD, 32'h22);
      wb_acc(A_CMD, 1'b1, 4'h3, 32'h33, 1'b0, r);
      rd_status("status_partial_sel", 32'h0008_0002);
      for (int i = 0; i < 3; i++) wr(A_CMD, 32'h44 + i);
      rd_status("status_lvl5", 32'h0000_0005);
      wr(A_CTRL, 32'h1);
      chk("flush_valid", bus.cmd_valid_o, 0);
      rd_status("status_flushed", 32'h0009_0000);
      wr(A_RSV, 32'hFFFF_FFFF);
      wb_acc(A_RSV, 1'b0, 4'hF, 32'h0, 1'b0, r);
      chk("reserved_read", r, 0);

      // Reset while an ack is on the bus.
      for (int i = 0; i < 6; i++) wr(A_CMD, $urandom);
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_STAT;
      @(posedge clk); #1;
      chk("pre_reset_ack", bus.wbs_ack_o, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_ack", bus.wbs_ack_o, 0);
      chk("async_reset_valid", bus.cmd_valid_o, 0);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rd_status("status_after_reset", 32'h0009_0000);

      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3000_0010;
      repeat (6) begin
         @(posedge clk); #1 chk("out_of_window_ack", bus.wbs_ack_o, 0);
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;

      for (int i = 0; i < 1200; i++) begin
         @(posedge clk); #1;
         bus.cmd_ready_i = ($urandom_range(0, 2) == 0);
         if (i % 2 == 0) begin
            if ($urandom_range(0, 3) != 0) begin
               k = $urandom_range(0, 11);
               bus.wbs_cyc_i = 1'b1;
               bus.wbs_stb_i = ($urandom_range(0, 9) != 0);
               bus.wbs_dat_i = $urandom;
               bus.wbs_sel_i = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
               bus.wbs_we_i  = 1'b1;
               bus.wbs_adr_i = A_CMD | 32'($urandom_range(0, 3));
               if (k == 7) begin
                  bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_STAT;
               end else if (k == 8) begin
                  bus.wbs_adr_i = A_CTRL;
                  bus.wbs_dat_i = ($urandom_range(0, 4) == 0) ? 32'h3 : 32'h2;
               end else if (k == 9) begin
                  bus.wbs_we_i = 1'($urandom); bus.wbs_adr_i = A_RSV;
               end else if (k == 10) begin
                  bus.wbs_we_i = 1'($urandom); bus.wbs_adr_i = A_CMD;
               end else if (k == 11) begin
                  bus.wbs_adr_i = ($urandom_range(0, 1) == 0) ? 32'h3000_0010 : 32'h2FFF_FFFC;
               end
            end else begin
               bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
            end
         end else if ($urandom_range(0, 3) != 0) begin
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.cmd_ready_i = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("final_drain", bus.cmd_valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_cmd_fifo.md
# wb_cmd_fifo

Wishbone slave that sits between the management-SoC Wishbone port of the user project and the rapcores motion engine. The firmware pushes 32-bit motion command words through a memory-mapped register. The block buffers them in a FIFO and presents them to the motion engine on a valid/ready stream. It also exposes level, full/empty, overflow and low-water status for firmware flow control.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 words (8).
- `BASE_ADDR`, default 32'h3000_0000: register window base. The window is 16 bytes.
- `LOW_WATER`, default 2: the low-water flag is set when level <= LOW_WATER.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_ni`, in, 1: asynchronous, active-low reset.
- `wbs_cyc_i`, in, 1: Wishbone cycle.
- `wbs_stb_i`, in, 1: Wishbone strobe.
- `wbs_we_i`, in, 1: write enable.
- `wbs_sel_i`, in, 4: byte selects.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_dat_i`, in, 32: write data.
- `wbs_ack_o`, out, 1: registered acknowledge.
- `wbs_dat_o`, out, 32: registered read data.
- `cmd_valid_o`, out, 1: the FIFO head is valid.
- `cmd_data_o`, out, 32: the FIFO head word.
- `cmd_ready_i`, in, 1: the motion engine accepts the head word.
- `lowwater_o`, out, 1: level <= LOW_WATER (interrupt to firmware).

## Operation
- Decode: an access is selected when cyc & stb & (adr[31:4] == BASE_ADDR[31:4]) & !ack. Register index is adr[3:2].
- Register 0, CMD (write-only; reads return 0):
  - A write with sel == 4'hF pushes dat_i if the FIFO is not full.
  - If the FIFO is full, the word is dropped and OVF (sticky) is set.
  - A write with any other sel is acked with no push.
- Register 1, STATUS (read-only):
  - [DEPTH_LOG2:0] = level.
  - bit16 = empty, bit17 = full, bit18 = OVF, bit19 = lowwater.
  - All other bits read 0.
- Register 2, CTRL (write-only, self-clearing, reads 0):
  - bit0 = flush: level, read pointer and write pointer go to 0.
  - bit1 = clear OVF.
  - Both bits may be set in one write.
- Register 3: reserved. Writes are ignored and reads return 0, but the access is still acked.
- FIFO storage:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo the depth.
  - Level counter is DEPTH_LOG2+1 bits wide.
  - full = (level == 2^DEPTH_LOG2); empty = (level == 0).
- Stream side:
  - cmd_valid_o = !empty.
  - cmd_data_o = mem[rd_ptr].
  - A pop occurs when cmd_valid_o & cmd_ready_i.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and the level is unchanged.
  - The full check uses the pre-cycle level, so a push to a full FIFO is rejected even if a pop occurs that cycle.
  - A flush and a pop in the same cycle: flush wins.
- OVF set and clear in the same cycle cannot coincide, because both require a Wishbone write.

## Timing
- Reset (wb_rst_ni low, asynchronous) forces the following; the FIFO memory contents are don't-care.
  - Outputs: wbs_ack_o = 0, wbs_dat_o = 0, cmd_valid_o = 0, cmd_data_o = 0 (memory is don't-care, so this is satisfied by gating cmd_data_o with !empty or by resetting the storage), lowwater_o = 1 (level 0).
  - Internal state: OVF = 0, pointers = 0, level = 0.
- Wishbone handshake:
  - Selected in cycle N → ack high for exactly cycle N+1, then low.
  - dat_o is valid during the ack cycle and is 0 otherwise.
  - Back-to-back accesses are acked at most every other cycle.
  - Unselected addresses are never acked.
- A push commits on the edge ending cycle N. cmd_valid_o and the level reflect the push from cycle N+1.
- A pop commits on the edge where valid & ready. The next head word is presented in the following cycle, so sustained throughput is one word per cycle.
- A flush takes effect on the edge ending cycle N. cmd_valid_o = 0 from N+1.
- STATUS reads sample the state at cycle N, before any same-edge update.
- lowwater_o is registered-equivalent: it is derived combinationally from the registered level.
- Reset asserted mid-transfer drops any pending ack and empties the FIFO.

## Test plan
- Reset, then read STATUS (0x3000_0004): ack 1 cycle later, data = 0x0009_0000 (empty, lowwater set), cmd_valid_o = 0.
- Push 0xA1, 0xB2, 0xC3 with cmd_ready_i = 0: STATUS level = 3, lowwater = 0. Then raise ready: the stream delivers A1, B2, C3 on consecutive cycles, then valid drops.
- Push 9 words with ready = 0: the 9th is acked but dropped. STATUS = 0x0006_0008 (full, OVF, level 8). Write CTRL = 0x2: OVF clears.
- Full FIFO, ready = 1 while pushing in the same cycle: the push is rejected and OVF is set, and level becomes 7. Separately, at level 4, a simultaneous push and pop keeps level 4 with correct ordering.
- Write CMD with sel = 4'h3: acked with no push. Write CTRL = 0x1 at level 5: cmd_valid_o = 0 next cycle and STATUS level = 0.
- Assert wb_rst_ni low mid-burst with level 6 and ack pending: ack drops immediately and level = 0 after release. An access at 0x3000_0010 (out of window) is never acked.
